// File: rtl/tt_sweep.sv
// Truth-table sweeper: walks a 7-input vector through all 128 codes, samples f_in
// after SETTLE cycles per vector and compares against a latched expected table.
// Optional ones counter enabled by defining TT_SWEEP_ONES_CNT_EN.
module tt_sweep #(
   parameter int SETTLE = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [127:0] exp_tt,
   input  logic         f_in,
   output logic         x0,
   output logic         x1,
   output logic         x2,
   output logic         x3,
   output logic         x4,
   output logic         x5,
   output logic         x6,
   output logic         busy,
   output logic         done,
   output logic [127:0] tt,
   output logic         match,
   output logic [7:0]   ones_cnt
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [3:0] HOLD_LAST = 4'(SETTLE - 1);

   state_t       state;
   logic [6:0]   idx;
   logic [3:0]   hold;
   logic [127:0] exp_q;
   logic         sample;

   assign sample = (hold == HOLD_LAST);

   // idx is parked at 0 outside RUN, so it can drive the vector bits directly
   assign {x6, x5, x4, x3, x2, x1, x0} = idx;
   assign match = done & (tt == exp_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         idx   <= '0;
         hold  <= '0;
         tt    <= '0;
         exp_q <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state <= RUN;
                  idx   <= '0;
                  hold  <= '0;
                  tt    <= '0;
                  exp_q <= exp_tt;
                  busy  <= 1'b1;
                  done  <= 1'b0;
               end
            end
            RUN: begin
               if (sample) begin
                  tt[idx] <= f_in;
                  hold    <= '0;
                  if (idx == 7'd127) begin
                     state <= DONE;
                     idx   <= '0;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     idx <= idx + 7'd1;
                  end
               end else begin
                  hold <= hold + 4'd1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

`ifdef TT_SWEEP_ONES_CNT_EN
   logic [7:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (state != RUN && start) begin
         cnt <= '0;
      end else if (state == RUN && sample && f_in) begin
         cnt <= cnt + 8'd1;
      end
   end

   assign ones_cnt = cnt;
`else
   assign ones_cnt = '0;
`endif

endmodule
